// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : led_sequencer
// Description: Multi-channel LED driver. In MANUAL state the registered
//              command pattern drives the LEDs. After a configurable number of
//              idle timebase ticks it switches to AUTO, which chases a single
//              lit LED across the channels. Any command returns it to MANUAL.
//              All LED outputs are gated by a global PWM brightness.
// Revision   : 1.0 - initial release
// ============================================================================
module led_sequencer #(
  parameter int N_LEDS     = 3,
  parameter int TICK_DIV   = 50000,
  parameter int IDLE_TICKS = 20,
  parameter int STEP_TICKS = 5,
  parameter int PWM_W      = 4
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [N_LEDS-1:0]                                cmd,
  input  logic [PWM_W-1:0]                                 brightness,
  output logic [N_LEDS-1:0]                                leds,
  output logic                                             auto_mode,
  output logic [((N_LEDS > 2) ? $clog2(N_LEDS) : 1)-1:0]   active_idx
);

  localparam int C_IDX_W  = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;
  localparam int C_PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int C_IDLE_W = (IDLE_TICKS > 2) ? $clog2(IDLE_TICKS) : 1;
  localparam int C_STEP_W = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;

  localparam logic [C_PRE_W-1:0]  C_PRE_LAST  = C_PRE_W'(TICK_DIV - 1);
  localparam logic [C_IDLE_W-1:0] C_IDLE_LAST = C_IDLE_W'(IDLE_TICKS - 1);
  localparam logic [C_STEP_W-1:0] C_STEP_LAST = C_STEP_W'(STEP_TICKS - 1);
  localparam logic [C_IDX_W-1:0]  C_IDX_LAST  = C_IDX_W'(N_LEDS - 1);

  localparam logic [0:0] S_MANUAL = 1'b0;
  localparam logic [0:0] S_AUTO   = 1'b1;

  logic [N_LEDS-1:0]   r_cmd_q;
  logic [C_PRE_W-1:0]  r_pre;
  logic [C_IDLE_W-1:0] r_idle;
  logic [C_STEP_W-1:0] r_step;
  logic [C_IDX_W-1:0]  r_active_idx;
  logic [PWM_W-1:0]    r_pwm;
  logic [N_LEDS-1:0]   r_leds;
  logic [0:0]          r_state;

  logic [0:0]          w_state_nxt;
  logic                w_tick;
  logic                w_cmd_any;
  logic                w_step_done;
  logic                w_pwm_on;
  logic [N_LEDS-1:0]   w_pattern;
  logic                w_auto;

  assign w_tick      = (r_pre == C_PRE_LAST);
  assign w_cmd_any   = |r_cmd_q;
  assign w_step_done = w_tick && (r_step == C_STEP_LAST);
  // Full-scale brightness means always on, so 100% duty is reachable.
  assign w_pwm_on    = (r_pwm < brightness) || (&brightness);

  // Single register stage on the command; every decision looks at r_cmd_q.
  always_ff @(posedge clk) begin
    if (reset) r_cmd_q <= '0;
    else       r_cmd_q <= cmd;
  end

  // Timebase prescaler: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (reset)             r_pre <= '0;
    else if (w_tick)       r_pre <= '0;
    else                   r_pre <= r_pre + 1'b1;
  end

  // Idle tick counter, cleared by any command, saturating at its last value.
  always_ff @(posedge clk) begin
    if (reset)                                 r_idle <= '0;
    else if (w_cmd_any)                        r_idle <= '0;
    else if (w_tick && (r_idle != C_IDLE_LAST)) r_idle <= r_idle + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_MANUAL;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: enter AUTO after enough idle ticks, leave on any command.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_MANUAL: if (w_tick && !w_cmd_any && (r_idle == C_IDLE_LAST)) w_state_nxt = S_AUTO;
      S_AUTO:   if (w_cmd_any) w_state_nxt = S_MANUAL;
      default:  w_state_nxt = S_MANUAL;
    endcase
  end

  // Chase position and step counter; held at zero outside AUTO so entry starts clean.
  always_ff @(posedge clk) begin
    if (reset || (r_state != S_AUTO) || w_cmd_any) begin
      r_step       <= '0;
      r_active_idx <= '0;
    end else if (w_step_done) begin
      r_step       <= '0;
      r_active_idx <= (r_active_idx == C_IDX_LAST) ? '0 : r_active_idx + 1'b1;
    end else if (w_tick) begin
      r_step       <= r_step + 1'b1;
    end
  end

  // Free-running PWM counter; brightness changes never restart it.
  always_ff @(posedge clk) begin
    if (reset) r_pwm <= '0;
    else       r_pwm <= r_pwm + 1'b1;
  end

  // FSM outputs: LED pattern and AUTO indication.
  always_comb begin
    w_pattern = '0;
    w_auto    = 1'b0;
    case (r_state)
      S_AUTO: begin
        w_auto = 1'b1;
        for (int i = 0; i < N_LEDS; i++) begin
          w_pattern[i] = (r_active_idx == C_IDX_W'(i));
        end
      end
      default: w_pattern = r_cmd_q;
    endcase
  end

  // Registered LED drive gated by the PWM duty.
  always_ff @(posedge clk) begin
    if (reset) r_leds <= '0;
    else       r_leds <= w_pattern & {N_LEDS{w_pwm_on}};
  end

  assign leds       = r_leds;
  assign auto_mode  = w_auto;
  assign active_idx = r_active_idx;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_led_sequencer
// Description: Self-checking bench for led_sequencer with a cycle-level
//              behavioural model expressed in elapsed ticks and cycles.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

  localparam int N  = 3;
  localparam int TD = 4;
  localparam int IT = 3;
  localparam int ST = 2;
  localparam int PW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] cmd;
  logic [PW-1:0] brightness;
  logic [N-1:0] leds;
  logic         auto_mode;
  logic [1:0]   active_idx;

  int total = 0;
  int bad   = 0;

  // Model state: elapsed quantities rather than hardware counters.
  int       m_cyc;        // non-reset edges since last reset
  int       m_idle_ticks; // ticks seen since last nonzero registered command
  int       m_auto_ticks; // ticks spent in AUTO since entry
  bit       m_auto;
  bit [N-1:0] m_cmdq;
  bit [N-1:0] m_leds;

  led_sequencer #(
    .N_LEDS(N), .TICK_DIV(TD), .IDLE_TICKS(IT), .STEP_TICKS(ST), .PWM_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .brightness(brightness),
    .leds(leds), .auto_mode(auto_mode), .active_idx(active_idx)
  );

  always #5 clk = ~clk;

  function automatic int exp_idx();
    return m_auto ? (m_auto_ticks / ST) % N : 0;
  endfunction

  // Advance one clock, updating the model from the values sampled at the edge.
  task automatic clk_step();
    bit tick, pwm_on, nxt_auto;
    bit [N-1:0] pattern;
    @(posedge clk);
    if (reset) begin
      m_cyc = 0; m_idle_ticks = 0; m_auto_ticks = 0;
      m_auto = 0; m_cmdq = '0; m_leds = '0;
    end else begin
      tick    = ((m_cyc % TD) == TD - 1);
      pwm_on  = ((m_cyc % 16) < int'(brightness)) || (brightness == 4'hF);
      pattern = m_auto ? (N'(1) << exp_idx()) : m_cmdq;
      m_leds  = pwm_on ? pattern : '0;
      if (m_auto) nxt_auto = (m_cmdq == 0);
      else        nxt_auto = tick && (m_cmdq == 0) && (m_idle_ticks >= IT - 1);
      if (nxt_auto && m_auto && tick) m_auto_ticks++;
      else if (!(nxt_auto && m_auto)) m_auto_ticks = 0;
      m_auto = nxt_auto;
      if (m_cmdq != 0) m_idle_ticks = 0;
      else if (tick)   m_idle_ticks++;
      m_cmdq = cmd;
      m_cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; cmd = '0; brightness = 4'hF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) reset = 0;
      clk_step();
      total += 3;
      if (leds !== 3'b000) begin bad++; $display("FAIL reset_leds cyc=%0d got=%b exp=000", i, leds); end
      if (auto_mode !== 1'b0) begin bad++; $display("FAIL reset_auto cyc=%0d got=%b exp=0", i, auto_mode); end
      if (active_idx !== 2'd0) begin bad++; $display("FAIL reset_idx cyc=%0d got=%0d exp=0", i, active_idx); end
    end
  endtask

  task automatic test_manual();
    bit [N-1:0] pats [2] = '{3'b001, 3'b011};
    brightness = 4'hF;
    foreach (pats[p]) begin
      cmd = pats[p];
      for (int i = 0; i < 6; i++) begin
        clk_step();
        total += 2;
        if (leds !== m_leds) begin bad++; $display("FAIL manual_model got=%b exp=%b", leds, m_leds); end
        if (i >= 1 && leds !== pats[p]) begin bad++; $display("FAIL manual_latency i=%0d got=%b exp=%b", i, leds, pats[p]); end
      end
    end
  endtask

  task automatic test_auto_chase();
    int guard, run;
    int idx_seen [$];
    cmd = '0; brightness = 4'hF;
    guard = 0;
    while (!auto_mode && guard < 40) begin clk_step(); guard++; end
    total++;
    if (!auto_mode) begin bad++; $display("FAIL auto_entry got=0 exp=1 after %0d cycles", guard); end
    total++;
    if (active_idx !== 2'd0) begin bad++; $display("FAIL auto_entry_idx got=%0d exp=0", active_idx); end
    idx_seen.push_back(0);
    // Wait for each new lit LED and measure how long it is held.
    for (int s = 0; s < 3; s++) begin
      guard = 0;
      while (leds !== (N'(1) << ((s + 1) % N)) && guard < 20) begin
        clk_step(); guard++;
        total += 3;
        if (leds !== m_leds) begin bad++; $display("FAIL chase_leds got=%b exp=%b", leds, m_leds); end
        if (auto_mode !== m_auto) begin bad++; $display("FAIL chase_auto got=%b exp=%b", auto_mode, m_auto); end
        if (int'(active_idx) !== exp_idx()) begin bad++; $display("FAIL chase_idx got=%0d exp=%0d", active_idx, exp_idx()); end
      end
      idx_seen.push_back(int'(active_idx));
      run = 0;
      while (leds === (N'(1) << ((s + 1) % N)) && run < 20) begin clk_step(); run++; end
      if (s < 2) begin
        total++;
        if (run != 8) begin bad++; $display("FAIL chase_hold step=%0d got=%0d exp=8", s, run); end
      end
    end
    total++;
    if (idx_seen[0] != 0 || idx_seen[1] != 1 || idx_seen[2] != 2 || idx_seen[3] != 0) begin
      bad++; $display("FAIL chase_idx_seq got=%0d,%0d,%0d,%0d exp=0,1,2,0", idx_seen[0], idx_seen[1], idx_seen[2], idx_seen[3]);
    end
  endtask

  task automatic test_exit_auto();
    int guard = 0;
    cmd = '0; brightness = 4'hF;
    while (!(auto_mode && active_idx == 2'd1) && guard < 60) begin clk_step(); guard++; end
    total++;
    if (!(auto_mode && active_idx == 2'd1)) begin bad++; $display("FAIL exit_setup got auto=%b idx=%0d exp auto=1 idx=1", auto_mode, active_idx); end
    cmd = 3'b100;
    clk_step();
    clk_step();
    total += 2;
    if (auto_mode !== 1'b0) begin bad++; $display("FAIL exit_auto got=%b exp=0", auto_mode); end
    if (active_idx !== 2'd0) begin bad++; $display("FAIL exit_idx got=%0d exp=0", active_idx); end
    clk_step();
    total++;
    if (leds !== 3'b100) begin bad++; $display("FAIL exit_leds got=%b exp=100", leds); end
    cmd = '0;
    for (int i = 0; i < 30; i++) begin
      clk_step();
      total += 3;
      if (i < 8 && auto_mode !== 1'b0) begin bad++; $display("FAIL exit_no_reentry i=%0d got=%b exp=0", i, auto_mode); end
      if (auto_mode !== m_auto) begin bad++; $display("FAIL exit_model_auto got=%b exp=%b", auto_mode, m_auto); end
      if (leds !== m_leds) begin bad++; $display("FAIL exit_model_leds got=%b exp=%b", leds, m_leds); end
    end
  endtask

  task automatic test_pwm();
    int on_cnt;
    cmd = 3'b111; brightness = 4'd4;
    for (int i = 0; i < 4; i++) clk_step();
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      clk_step();
      if (leds === 3'b111) on_cnt++;
      total++;
      if (leds !== 3'b111 && leds !== 3'b000) begin bad++; $display("FAIL pwm_shape got=%b exp=111/000", leds); end
    end
    total++;
    if (on_cnt != 4) begin bad++; $display("FAIL pwm_duty got=%0d exp=4", on_cnt); end
    brightness = 4'd0;
    clk_step();
    for (int i = 0; i < 20; i++) begin
      clk_step();
      total++;
      if (leds !== 3'b000) begin bad++; $display("FAIL pwm_zero got=%b exp=000", leds); end
    end
  endtask

  task automatic test_reset_mid_auto();
    int guard = 0;
    cmd = '0; brightness = 4'hF;
    while (!(auto_mode && active_idx == 2'd2) && guard < 100) begin clk_step(); guard++; end
    total++;
    if (!(auto_mode && active_idx == 2'd2)) begin bad++; $display("FAIL rstmid_setup got auto=%b idx=%0d exp auto=1 idx=2", auto_mode, active_idx); end
    reset = 1;
    clk_step();
    reset = 0;
    total += 3;
    if (leds !== 3'b000) begin bad++; $display("FAIL rstmid_leds got=%b exp=000", leds); end
    if (auto_mode !== 1'b0) begin bad++; $display("FAIL rstmid_auto got=%b exp=0", auto_mode); end
    if (active_idx !== 2'd0) begin bad++; $display("FAIL rstmid_idx got=%0d exp=0", active_idx); end
    // Entry timing afterwards depends on the prescaler having restarted from 0.
    for (int i = 0; i < 40; i++) begin
      clk_step();
      total += 3;
      if (leds !== m_leds) begin bad++; $display("FAIL rstmid_model_leds got=%b exp=%b", leds, m_leds); end
      if (auto_mode !== m_auto) begin bad++; $display("FAIL rstmid_model_auto got=%b exp=%b", auto_mode, m_auto); end
      if (int'(active_idx) !== exp_idx()) begin bad++; $display("FAIL rstmid_model_idx got=%0d exp=%0d", active_idx, exp_idx()); end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 80; seg++) begin
      cmd        = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom_range(1, 7));
      brightness = PW'($urandom_range(0, 15));
      hold       = $urandom_range(1, 40);
      reset      = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < hold; i++) begin
        clk_step();
        reset = 0;
        total += 3;
        if (leds !== m_leds) begin bad++; $display("FAIL rand_leds seg=%0d got=%b exp=%b", seg, leds, m_leds); end
        if (auto_mode !== m_auto) begin bad++; $display("FAIL rand_auto seg=%0d got=%b exp=%b", seg, auto_mode, m_auto); end
        if (int'(active_idx) !== exp_idx()) begin bad++; $display("FAIL rand_idx seg=%0d got=%0d exp=%0d", seg, active_idx, exp_idx()); end
      end
    end
  endtask

  initial begin
    reset = 1; cmd = '0; brightness = '0;
    m_cyc = 0; m_idle_ticks = 0; m_auto_ticks = 0; m_auto = 0; m_cmdq = '0; m_leds = '0;
    test_reset();
    test_manual();
    test_auto_chase();
    test_exit_auto();
    test_pwm();
    test_reset_mid_auto();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
